// File: rtl/refill_pkg.sv
// Shared refill-engine constants and the refill FSM state type, used by the I-cache and its refill unit.
package refill_pkg;

    localparam int unsigned NrWordsPerLine = 4;
    localparam int unsigned WordBits       = 32;
    localparam int unsigned LineSize       = WordBits * NrWordsPerLine;
    localparam int unsigned WordOffsetBits = $clog2(NrWordsPerLine);
    localparam int unsigned LineOffsetBits = WordOffsetBits + 2;
    localparam int unsigned CntBits        = WordOffsetBits + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        COOL  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/line_refill_unit.sv
// I-cache line refill engine: fetches one line as single-word bus reads and returns it line-wide.
// Define CRITICAL_WORD_FIRST_EN to start the fetch at the missing word and wrap around the line.
module line_refill_unit
    import refill_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [31:0]         req_addr_i,
    input  logic                req_en_i,
    output logic                line_valid_o,
    output logic [LineSize-1:0] line_data_o,
    output logic                bus_req_o,
    output logic [31:0]         bus_addr_o,
    input  logic                bus_gnt_i,
    input  logic                bus_rvalid_i,
    input  logic [31:0]         bus_rdata_i
);

    refill_state_e                  state_q, state_d;
    logic [31-LineOffsetBits:0]     base_q, base_d;
    logic [WordOffsetBits-1:0]      start_q, start_d;
    logic [CntBits-1:0]             issue_q, issue_d;
    logic [CntBits-1:0]             resp_q, resp_d;
    logic [CntBits-1:0]             outst_q, outst_d;
    logic [LineSize-1:0]            line_data_d;
    logic                           line_valid_d;
    logic                           bus_req_d;
    logic [31:0]                    bus_addr_d;
    logic                           grant;
    logic                           resp;
    logic [WordOffsetBits-1:0]      slot;
    logic [WordOffsetBits-1:0]      issue_idx;
    logic                           unused_addr_bits;

    assign unused_addr_bits = ^req_addr_i[LineOffsetBits-1:0];

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            start_q      <= '0;
            issue_q      <= '0;
            resp_q       <= '0;
            outst_q      <= '0;
            line_data_o  <= '0;
            line_valid_o <= 1'b0;
            bus_req_o    <= 1'b0;
            bus_addr_o   <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            start_q      <= start_d;
            issue_q      <= issue_d;
            resp_q       <= resp_d;
            outst_q      <= outst_d;
            line_data_o  <= line_data_d;
            line_valid_o <= line_valid_d;
            bus_req_o    <= bus_req_d;
            bus_addr_o   <= bus_addr_d;
        end
    end

    // Next state, counters, line assembly and the registered bus request for the next cycle
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        start_d      = start_q;
        issue_d      = issue_q;
        resp_d       = resp_q;
        outst_d      = outst_q;
        line_data_d  = line_data_o;
        line_valid_d = 1'b0;
        bus_req_d    = 1'b0;
        bus_addr_d   = '0;
        issue_idx    = '0;

        grant = bus_req_o && bus_gnt_i;
        resp  = (state_q == FETCH) && bus_rvalid_i;
        slot  = WordOffsetBits'(CntBits'(start_q) + resp_q);

        unique case (state_q)
            IDLE: begin
                if (req_en_i) begin
                    base_d  = req_addr_i[31:LineOffsetBits];
`ifdef CRITICAL_WORD_FIRST_EN
                    start_d = req_addr_i[2 +: WordOffsetBits];
`else
                    start_d = '0;
`endif
                    issue_d = '0;
                    resp_d  = '0;
                    outst_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (grant) begin
                    issue_d = issue_q + CntBits'(1);
                end
                outst_d = outst_q + CntBits'(grant) - CntBits'(resp);
                if (resp) begin
                    line_data_d[int'(slot)*WordBits +: WordBits] = bus_rdata_i;
                    resp_d = resp_q + CntBits'(1);
                    if (resp_d == CntBits'(NrWordsPerLine)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = COOL;
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        line_valid_d = (state_d == DONE);

        // Request is held with a stable address until granted, throttled by outstanding reads
        if (state_d == FETCH) begin
            issue_idx  = WordOffsetBits'(CntBits'(start_d) + issue_d);
            bus_addr_d = {base_d, issue_idx, 2'b00};
            bus_req_d  = (issue_d < CntBits'(NrWordsPerLine)) &&
                         (outst_d < CntBits'(MaxOutstanding));
        end
    end

endmodule
